// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: shared state encoding, default sizing and grid-derived tag widths.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 13
`endif
`ifndef DEPTH
`define DEPTH 2500
`endif
package ram_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int cell_xw(input int grid_w);
    return $clog2(grid_w);
  endfunction
  function automatic int cell_yw(input int depth, input int grid_w);
    return $clog2(depth / grid_w);
  endfunction
endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: 2-entry output FIFO; head word stays put until popped.
module stream_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  assign valid = count != 2'd0;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: scans a RAM frame in index order into a tagged valid/ready stream.
// Define STREAM_LOOP_EN to keep rescanning frames while start is held high.
module ram_stream_reader import ram_stream_reader_pkg::*; #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDRESS_WIDTH = `ADDRESS_WIDTH,
  parameter int DEPTH = `DEPTH,
  parameter int GRID_W = 50,
  localparam int XW = cell_xw(GRID_W),
  localparam int YW = cell_yw(DEPTH, GRID_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_we,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic [XW-1:0]            m_x,
  output logic [YW-1:0]            m_y,
  output logic                     m_last
);
  localparam int ROWS = DEPTH / GRID_W;
  localparam int IW = $clog2(DEPTH);
  localparam int FW = DATA_WIDTH + XW + YW + 1;
  state_t state;
  logic [IW-1:0] idx;
  logic [XW-1:0] x, fl_x;
  logic [YW-1:0] y, fl_y;
  logic in_flight, fl_last, pop, issue, at_end, x_end, wrap;
  logic [1:0] occ;
  logic [FW-1:0] q;
`ifdef STREAM_LOOP_EN
  assign wrap = start;
`else
  assign wrap = 1'b0;
`endif
  assign ram_we = 1'b0;
  assign pop = m_valid && m_ready;
  assign at_end = idx == IW'(DEPTH - 1);
  assign x_end = x == XW'(GRID_W - 1);
  // never commit more RAM reads than the FIFO can still absorb
  assign issue = state == RUN && ({1'b0, occ} + {2'b0, in_flight} < 3'd2 + {2'b0, pop});
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      x <= '0;
      y <= '0;
      in_flight <= 1'b0;
      fl_x <= '0;
      fl_y <= '0;
      fl_last <= 1'b0;
      ram_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      in_flight <= issue;
      done <= 1'b0;
      if (issue) begin
        ram_addr <= ADDRESS_WIDTH'({idx, 1'b0});
        fl_x <= x;
        fl_y <= y;
        fl_last <= at_end;
        idx <= at_end ? '0 : idx + 1'b1;
        x <= x_end ? '0 : x + 1'b1;
        y <= x_end ? (y == YW'(ROWS - 1) ? '0 : y + 1'b1) : y;
      end
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy <= 1'b1;
        end
        RUN: if (issue && at_end && !wrap) state <= DRAIN;
        DRAIN: if (pop && m_last) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  stream_skid_fifo #(.W(FW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_flight),
    .din({ram_rdata, fl_x, fl_y, fl_last}),
    .pop(pop),
    .valid(m_valid),
    .dout(q),
    .count(occ)
  );
  assign {m_data, m_x, m_y} = q[FW-1:1];
  assign m_last = m_valid & q[0];
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: random RAM contents and ready patterns checked against an index-order frame model.
module tb_ram_stream_reader;
  localparam int DW = 8, AW = 13, DEPTH = 2500, GW = 50, LIM = 4 * DEPTH + 200;
  logic clk = 1'b0;
  logic rst, start, busy, done, ram_we, m_valid, m_ready, m_last;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata, m_data;
  logic [5:0] m_x, m_y;
  logic [DW-1:0] mem [DEPTH];
  int n_tests = 0, n_fail = 0, n_beats = 0, n_last = 0, n_done = 0, beat = 0;
  bit mon_en = 1'b0, prev_stall = 1'b0;
  logic [20:0] prev_out;

  always #5 clk = ~clk;
  assign ram_rdata = mem[ram_addr >> 1];

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .GRID_W(GW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_x(m_x), .m_y(m_y), .m_last(m_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // beat k of every frame must carry mem[k] at column k%GW, row k/GW
  always @(negedge clk) begin
    if (rst) begin
      beat = 0;
      prev_stall = 1'b0;
    end else if (mon_en) begin
      check("addr_range", 32'(ram_addr <= AW'(2 * (DEPTH - 1))), 1);
      if (prev_stall) check("stall_hold", {m_valid, m_data, m_x, m_y, m_last}, {1'b1, prev_out});
      if (m_valid && m_ready) begin
        check("beat_data", m_data, mem[beat]);
        check("beat_x", m_x, beat % GW);
        check("beat_y", m_y, beat / GW);
        check("beat_last", m_last, beat == DEPTH - 1);
        n_beats++;
        n_last += int'(m_last);
        beat = (beat + 1) % DEPTH;
      end
      if (done) n_done++;
      prev_stall = m_valid && !m_ready;
      prev_out = {m_data, m_x, m_y, m_last};
    end
  end

  // mode 0: ready held high, 1: ready toggling with stray starts, 2: random ready
  task automatic run_frame(input int mode);
    int cyc;
    n_beats = 0;
    n_last = 0;
    n_done = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check("busy_on", busy, 1);
    check("no_early_valid", m_valid, 0);
    while (!done && cyc < LIM) begin
      m_ready = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : ($urandom_range(0, 3) != 0);
      start = mode == 1 && (cyc == 100 || cyc == DEPTH);
      @(posedge clk); #1;
      cyc++;
      if (mode == 0 && cyc == 2) check("lat_n1", m_valid, 0);
      if (mode == 0 && cyc == 3) check("lat_n2", m_valid, 1);
    end
    start = 1'b0;
    check("done_seen", done, 1);
    if (mode == 0) check("frame_cycles", cyc, DEPTH + 3);
    repeat (4) @(posedge clk);
    #1;
    check("busy_off", busy, 0);
    check("done_pulse", done, 0);
    check("idle_valid", m_valid, 0);
    check("beat_count", n_beats, DEPTH);
    check("last_count", n_last, 1);
    check("done_count", n_done, 1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    rst = 1'b1;
    start = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_addr", ram_addr, 0);
    check("ram_we", ram_we, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_valid", m_valid, 0);
    run_frame(0);
    run_frame(1);
    run_frame(2);
    n_beats = 0;
    start = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < LIM && n_beats < 1000; c++) begin
      @(posedge clk); #1;
    end
    check("reach_1000", n_beats >= 1000, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", ram_addr, 0);
    check("arst_last", m_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", m_valid, 0);
    run_frame(2);
`ifdef STREAM_LOOP_EN
    begin
      int cyc;
      n_beats = 0;
      n_last = 0;
      n_done = 0;
      cyc = 0;
      start = 1'b1;
      m_ready = 1'b1;
      while (n_last < 1 && cyc < LIM) begin
        @(posedge clk); #1;
        cyc++;
      end
      start = 1'b0;
      while (!done && cyc < LIM) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("loop_done_seen", done, 1);
      repeat (4) @(posedge clk);
      #1;
      check("loop_beats", n_beats, 2 * DEPTH);
      check("loop_lasts", n_last, 2);
      check("loop_dones", n_done, 1);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, the cell word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default `ADDRESS_WIDTH, the RAM address width.
REQ-003 SHALL have parameter DEPTH, default `DEPTH (2500), the number of cells per frame.
REQ-004 SHALL have parameter GRID_W, default 50, the cells per row; DEPTH SHALL be a multiple of GRID_W.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse that begins a frame scan; ignored unless IDLE.
REQ-008 busy  out  1  high from the cycle after start is accepted until done.
REQ-009 done  out  1  one-cycle pulse after the last cell is transferred.
REQ-010 ram_addr  out  ADDRESS_WIDTH  RAM address, driven as 2*index (the RAM indexes by addr>>1).
REQ-011 ram_we  out  1  constant 0.
REQ-012 ram_rdata  in  DATA_WIDTH  RAM data_out, valid one cycle after ram_addr.
REQ-013 m_valid  out  1  stream data valid.
REQ-014 m_ready  in  1  downstream accept.
REQ-015 m_data  out  DATA_WIDTH  cell value.
REQ-016 m_x  out  clog2(GRID_W)  column of m_data.
REQ-017 m_y  out  clog2(DEPTH/GRID_W)  row of m_data.
REQ-018 m_last  out  1  high with index DEPTH-1.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-020 State transitions SHALL be: IDLE->RUN on start; RUN->DRAIN after issuing index DEPTH-1; DRAIN->DONE when the last beat transfers (m_valid&&m_ready&&m_last); DONE->IDLE unconditionally after 1 cycle, with done=1 in DONE.
REQ-021 SHALL issue indices 0..DEPTH-1 in ascending order, one per cycle, while credit exists.
REQ-022 Credit rule: an issue SHALL occur only when occupancy + in_flight - pop < 2, where occupancy is the 2-entry output FIFO count, in_flight is the issue from the previous cycle and pop is m_valid&&m_ready.
REQ-023 SHALL capture ram_rdata into the FIFO exactly one cycle after each issue, with x, y and last tags carried alongside.
REQ-024 ram_addr SHALL hold its value on non-issue cycles.
REQ-025 Latency: with start sampled on edge N, m_valid SHALL first assert after edge N+2.
REQ-026 With m_ready held at 1, the block SHALL sustain one beat per cycle and take DEPTH+3 cycles from start to done.
REQ-027 m_data, m_x, m_y and m_last SHALL be stable while m_valid=1 and m_ready=0.
REQ-028 The x counter SHALL wrap at GRID_W-1 to 0 and increment y; y SHALL wrap to 0 after DEPTH/GRID_W-1.
REQ-029 A start that arrives outside IDLE SHALL be ignored.
REQ-030 If a pop and a capture occur in the same cycle, occupancy SHALL be unchanged.

Reset
REQ-031 Asserting rst SHALL immediately force IDLE, FIFO empty, in_flight=0, ram_addr=0, counters=0, and busy=done=m_valid=m_last=0.
REQ-032 Reset asserted mid-frame SHALL discard all pending beats; the next start SHALL rescan from index 0.

Configuration
REQ-033 Macro STREAM_LOOP_EN: when defined, RUN SHALL wrap from index DEPTH-1 to 0 and continue for as long as start is held high (sampled at each wrap), with m_last still marking each frame end; done SHALL pulse only on the final frame.
REQ-034 Without STREAM_LOOP_EN, every start SHALL produce exactly one frame.

Structure
REQ-035 The state encoding and the GRID_W/DEPTH-derived widths SHALL live in the shared package/def.vh.
REQ-036 The 2-entry output FIFO SHALL be a sub-module named stream_skid_fifo.

Verification
REQ-037 Reset, start, m_ready=1 -> 2500 beats in order; data equals the ram0.mem contents; done pulses exactly 2503 cycles after start.
REQ-038 m_ready toggling 1010... -> no beat lost or duplicated; outputs stable while stalled; ram_addr never exceeds 4998.
REQ-039 Beat 49 -> m_x=49, m_y=0; beat 50 -> m_x=0, m_y=1; beat 2499 -> m_x=49, m_y=49, m_last=1.
REQ-040 rst pulsed at beat 1000, then start -> first beat has index 0 and busy re-asserts.
REQ-041 start pulsed during RUN -> ignored; exactly one frame is produced.
REQ-042 With STREAM_LOOP_EN and start held for 2 frames -> 5000 beats, m_last twice, done once.
